voice_allocator: RTL and testbench
==================================

# voice_allocator

Stateful voice-slot table that turns a stream of note-on/note-off events into slot assignments for the synth voices. It sits in the dispatcher between the MIDI event decoder and the voice bank. It is the writer side of the slot table: it owns the per-slot note registers that downstream note-to-slot lookups read. It allocates free slots, retriggers held notes, releases slots on note-off and, optionally, steals the oldest voice when all slots are busy.

## Interface
- NOTE_WIDTH, 7, width of a note number
- VOICE_COUNT, 8, number of voice slots; must be ≥2
- AGE_WIDTH, 8, width of each slot's saturating age counter
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- event_valid  in  1  event offered
- event_ready  out  1  block can accept an event
- event_on  in  1  1 = note-on, 0 = note-off
- event_note  in  NOTE_WIDTH  note number
- slot_valid  out  VOICE_COUNT  per-slot occupied flag (registered)
- slot_note  out  NOTE_WIDTH × VOICE_COUNT (unpacked array)  per-slot note (registered)
- update_valid  out  1  one-cycle pulse: a slot changed
- update_index  out  $clog2(VOICE_COUNT)  slot that changed
- update_active  out  1  1 = slot (re)started, 0 = slot released
- update_note  out  NOTE_WIDTH  note now (or last) held by that slot
- dropped  out  1  one-cycle pulse: event discarded without update

## Operation
- FSM with states IDLE, LOOKUP and COMMIT. event_ready = (state == IDLE).
- IDLE: on event_valid & event_ready, register the event and go to LOOKUP.
- LOOKUP: combinationally compute three values and register them, then go to COMMIT.
  - match: lowest valid slot with slot_note == note.
  - free: lowest invalid slot.
  - oldest: valid slot with the maximum age; ties go to the lowest index.
- COMMIT: perform the action below, then return to IDLE.
  - Note-on, match found: retrigger. Pulse update with active=1 for that slot and clear its age to 0.
  - Note-on, no match, free slot exists: allocate. Set slot_valid, write slot_note, clear age to 0, pulse update with active=1.
  - Note-on, table full: see Configuration.
  - Note-off, match found: clear slot_valid, keep slot_note unchanged, pulse update with active=0 and update_note = the released note.
  - Note-off, no match: pulse dropped; no table change.
- Ages: on every allocating or retriggering COMMIT, every other valid slot's age increments, saturating at 2^AGE_WIDTH−1. Invalid slots hold age 0.
- A note is never held by two slots at the same time.

## Timing
- Accept at cycle t. LOOKUP at t+1. COMMIT at t+2, where update_valid or dropped pulses and the table registers load at the end of the cycle.
- New table values are visible at t+3. event_ready returns high at t+3.
- Throughput is one event per 3 cycles. No back-to-back acceptance.
- update_valid and dropped are mutually exclusive and never high for more than one cycle.
- update_* fields are only meaningful while update_valid is high; they are held at their last values otherwise.
- Reset values:
  - state IDLE, event_ready=1
  - slot_valid all 0, slot_note all 0, ages all 0
  - update_valid=0, update_index=0, update_active=0, update_note=0, dropped=0
- Reset asserted mid-operation discards the in-flight event: no update or dropped pulse, and table cleared.
- Events presented while event_ready=0 are ignored. The upstream block holds them.

## Configuration
- VOICE_STEAL_EN defined: a note-on to a full table steals the oldest slot.
  - Overwrite slot_note and clear its age. slot_valid stays 1.
  - Pulse update with active=1 for that slot. dropped never fires for note-ons.
- VOICE_STEAL_EN undefined: a note-on to a full table pulses dropped and leaves the table unchanged.
  - The oldest-slot search and its registers are not synthesised.

## Structure
- dispatcher_pkg holds:
  - the note-event struct (on flag plus note)
  - the allocator state enum
  - the default NOTE_WIDTH, VOICE_COUNT and AGE_WIDTH constants
- One sub-module, oldest_select: a combinational argmax over ages masked by slot_valid, returning the lowest index on ties. Compiled only under VOICE_STEAL_EN.

## Test plan
- Reset, then note-on 60 → update at t+2 with index 0, active 1, note 60; slot_valid = 8'b0000_0001 at t+3; event_ready low for exactly 2 cycles.
- Note-on 60, 62, then note-off 60, then note-on 64 → note 64 reuses slot 0 (update index 0); slot 1 still holds 62.
- Note-on 60 twice → second event retriggers index 0; only one slot valid; slot 0 age is 0 and nothing else changes.
- Note-off 70 with no match → dropped pulses once at t+2; update_valid stays 0; table unchanged.
- Fill all 8 slots with notes 60–67, then note-on 70.
  - With VOICE_STEAL_EN: update index 0, note 70.
  - Without VOICE_STEAL_EN: dropped pulses and slot 0 still holds 60.
- Assert rst during the LOOKUP cycle of a note-on → no pulse, slot_valid = 0 and event_ready = 1 after release.

Source files
------------

// File: rtl/dispatcher_pkg.sv
// dispatcher_pkg: shared types and default sizes for the note dispatcher.
//   - NOTE_WIDTH_DEF / VOICE_COUNT_DEF / AGE_WIDTH_DEF : default block sizes
//   - alloc_state_t : voice allocator FSM states
//   - note_event_t  : one decoded note event (on flag + note) at default width
package dispatcher_pkg;

    localparam int NOTE_WIDTH_DEF  = 7;
    localparam int VOICE_COUNT_DEF = 8;
    localparam int AGE_WIDTH_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_COMMIT = 2'd2
    } alloc_state_t;

    typedef struct packed {
        logic                      on;
        logic [NOTE_WIDTH_DEF-1:0] note;
    } note_event_t;

endpackage

// File: rtl/oldest_select.sv
// oldest_select: combinational argmax over per-slot ages, masked by the slot
// valid flags. Ties resolve to the lowest slot index. Returns 0 when no slot
// is valid (the allocator only consults it for a full table).
// Compiled only when VOICE_STEAL_EN is defined.
// Ports:
//   valid      in  VOICE_COUNT            per-slot occupied flags
//   ages       in  AGE_WIDTH x VOICE_COUNT per-slot age counters
//   oldest_idx out $clog2(VOICE_COUNT)    index of the oldest valid slot
`ifdef VOICE_STEAL_EN
module oldest_select
    import dispatcher_pkg::*;
#(
    parameter int VOICE_COUNT = VOICE_COUNT_DEF,
    parameter int AGE_WIDTH   = AGE_WIDTH_DEF
) (
    input  logic [VOICE_COUNT-1:0]         valid,
    input  logic [AGE_WIDTH-1:0]           ages [VOICE_COUNT],
    output logic [$clog2(VOICE_COUNT)-1:0] oldest_idx
);

    localparam int IDX_W = $clog2(VOICE_COUNT);

    logic                 found;
    logic [AGE_WIDTH-1:0] best_age;

    // Strict '>' keeps the first (lowest-index) slot on equal ages.
    always_comb begin
        found      = 1'b0;
        best_age   = '0;
        oldest_idx = '0;
        for (int i = 0; i < VOICE_COUNT; i++) begin
            if (valid[i] && (!found || ages[i] > best_age)) begin
                found      = 1'b1;
                best_age   = ages[i];
                oldest_idx = IDX_W'(i);
            end
        end
    end

endmodule
`endif

// File: rtl/voice_allocator.sv
// voice_allocator: writer side of the voice slot table. Turns note-on/off
// events into slot allocations, retriggers and releases. One event per three
// cycles: IDLE (accept) -> LOOKUP (search, update pulse registered) ->
// COMMIT (update/dropped pulse visible, table loads at end of cycle).
// Optional feature macro: VOICE_STEAL_EN -- a note-on to a full table steals
// the oldest voice instead of being dropped.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   event_valid/ready event handshake (ready only in IDLE)
//   event_on, event_note  1 = note-on, 0 = note-off; note number
//   slot_valid, slot_note registered slot table
//   update_valid/index/active/note  one-cycle slot-change report
//   dropped           one-cycle pulse: event discarded without update
module voice_allocator
    import dispatcher_pkg::*;
#(
    parameter int NOTE_WIDTH  = NOTE_WIDTH_DEF,
    parameter int VOICE_COUNT = VOICE_COUNT_DEF,
    parameter int AGE_WIDTH   = AGE_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           event_valid,
    output logic                           event_ready,
    input  logic                           event_on,
    input  logic [NOTE_WIDTH-1:0]          event_note,
    output logic [VOICE_COUNT-1:0]         slot_valid,
    output logic [NOTE_WIDTH-1:0]          slot_note [VOICE_COUNT],
    output logic                           update_valid,
    output logic [$clog2(VOICE_COUNT)-1:0] update_index,
    output logic                           update_active,
    output logic [NOTE_WIDTH-1:0]          update_note,
    output logic                           dropped
);

    localparam int IDX_W = $clog2(VOICE_COUNT);

    alloc_state_t          state;
    logic                  ev_on;
    logic [NOTE_WIDTH-1:0] ev_note;
    logic                  cm_start;
    logic                  cm_release;
    logic [IDX_W-1:0]      cm_idx;

    logic                  m_found;
    logic [IDX_W-1:0]      m_idx;
    logic                  f_found;
    logic [IDX_W-1:0]      f_idx;
    logic                  lk_start;
    logic                  lk_release;
    logic [IDX_W-1:0]      lk_idx;

`ifdef VOICE_STEAL_EN
    // Ages only steer voice stealing, so they exist only in that build.
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;
    logic [AGE_WIDTH-1:0]  age [VOICE_COUNT];
    logic [IDX_W-1:0]      o_idx;

    oldest_select #(
        .VOICE_COUNT (VOICE_COUNT),
        .AGE_WIDTH   (AGE_WIDTH)
    ) u_oldest (
        .valid      (slot_valid),
        .ages       (age),
        .oldest_idx (o_idx)
    );
`endif

    assign event_ready = (state == ST_IDLE);

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        m_found = 1'b0;
        m_idx   = '0;
        f_found = 1'b0;
        f_idx   = '0;
        for (int i = VOICE_COUNT - 1; i >= 0; i--) begin
            if (slot_valid[i] && slot_note[i] == ev_note) begin
                m_found = 1'b1;
                m_idx   = IDX_W'(i);
            end
            if (!slot_valid[i]) begin
                f_found = 1'b1;
                f_idx   = IDX_W'(i);
            end
        end
    end

    // Action decision: a held note always retriggers its own slot, which
    // also guarantees no note is ever held by two slots.
    always_comb begin
        lk_start   = 1'b0;
        lk_release = 1'b0;
        lk_idx     = '0;
        if (ev_on) begin
            if (m_found) begin
                lk_start = 1'b1;
                lk_idx   = m_idx;
            end else if (f_found) begin
                lk_start = 1'b1;
                lk_idx   = f_idx;
            end
`ifdef VOICE_STEAL_EN
            else begin
                lk_start = 1'b1;
                lk_idx   = o_idx;
            end
`endif
        end else if (m_found) begin
            lk_release = 1'b1;
            lk_idx     = m_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            ev_on         <= 1'b0;
            ev_note       <= '0;
            cm_start      <= 1'b0;
            cm_release    <= 1'b0;
            cm_idx        <= '0;
            slot_valid    <= '0;
            update_valid  <= 1'b0;
            update_index  <= '0;
            update_active <= 1'b0;
            update_note   <= '0;
            dropped       <= 1'b0;
            for (int i = 0; i < VOICE_COUNT; i++) begin
                slot_note[i] <= '0;
`ifdef VOICE_STEAL_EN
                age[i]       <= '0;
`endif
            end
        end else begin
            update_valid <= 1'b0;
            dropped      <= 1'b0;
            case (state)
                // ---- IDLE: accept one event ----
                ST_IDLE: begin
                    if (event_valid) begin
                        ev_on   <= event_on;
                        ev_note <= event_note;
                        state   <= ST_LOOKUP;
                    end
                end
                // ---- LOOKUP: register decision; report pulses during COMMIT ----
                ST_LOOKUP: begin
                    cm_start   <= lk_start;
                    cm_release <= lk_release;
                    cm_idx     <= lk_idx;
                    if (lk_start || lk_release) begin
                        update_valid  <= 1'b1;
                        update_index  <= lk_idx;
                        update_active <= lk_start;
                        update_note   <= ev_note;
                    end else begin
                        dropped <= 1'b1;
                    end
                    state <= ST_COMMIT;
                end
                // ---- COMMIT: table loads at end of this cycle ----
                ST_COMMIT: begin
                    if (cm_start) begin
                        for (int i = 0; i < VOICE_COUNT; i++) begin
                            if (IDX_W'(i) == cm_idx) begin
                                slot_valid[i] <= 1'b1;
                                slot_note[i]  <= ev_note;
`ifdef VOICE_STEAL_EN
                                age[i]        <= '0;
                            end else if (slot_valid[i] && age[i] != AGE_MAX) begin
                                age[i]        <= age[i] + 1'b1;
`endif
                            end
                        end
                    end else if (cm_release) begin
                        slot_valid[cm_idx] <= 1'b0;
`ifdef VOICE_STEAL_EN
                        age[cm_idx]        <= '0;
`endif
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: table-driven directed sequences plus randomized events
// checked against a timestamp-based slot model (age = starts since the slot's
// last start, saturating).
module tb_voice_allocator;

    localparam int NW = 7;
    localparam int VC = 8;
`ifdef VOICE_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          event_valid = 1'b0;
    logic          event_ready;
    logic          event_on = 1'b0;
    logic [NW-1:0] event_note = '0;
    logic [VC-1:0] slot_valid;
    logic [NW-1:0] slot_note [VC];
    logic          update_valid;
    logic [2:0]    update_index;
    logic          update_active;
    logic [NW-1:0] update_note;
    logic          dropped;

    voice_allocator dut (
        .clk           (clk),
        .rst           (rst),
        .event_valid   (event_valid),
        .event_ready   (event_ready),
        .event_on      (event_on),
        .event_note    (event_note),
        .slot_valid    (slot_valid),
        .slot_note     (slot_note),
        .update_valid  (update_valid),
        .update_index  (update_index),
        .update_active (update_active),
        .update_note   (update_note),
        .dropped       (dropped)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: notes, occupancy and the global start count at each
    // slot's most recent start.
    int m_valid [VC];
    int m_note  [VC];
    int m_stamp [VC];
    int starts;

    typedef struct {
        bit       on;
        int       note;
        bit       upd;
        int       idx;
        bit       act;
        bit       drop;
        bit [7:0] valid;
    } vec_t;

    vec_t tab[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < VC; i++) begin
            m_valid[i] = 0;
            m_note[i]  = 0;
            m_stamp[i] = 0;
        end
        starts = 0;
    endtask

    function automatic int m_age(input int i);
        int a;
        if (m_valid[i] == 0) return 0;
        a = starts - m_stamp[i];
        return (a > 255) ? 255 : a;
    endfunction

    task automatic model_apply(input bit on, input int note,
                               output bit upd, output int idx, output bit act, output bit drop);
        int match = -1;
        int free  = -1;
        int tgt   = -1;
        upd = 0; idx = 0; act = 0; drop = 0;
        for (int i = 0; i < VC; i++) begin
            if (m_valid[i] != 0 && m_note[i] == note && match < 0) match = i;
            if (m_valid[i] == 0 && free < 0) free = i;
        end
        if (on) begin
            if (match >= 0) tgt = match;
            else if (free >= 0) tgt = free;
            else if (STEAL) begin
                for (int i = 0; i < VC; i++)
                    if (tgt < 0 || m_age(i) > m_age(tgt)) tgt = i;
            end
            if (tgt >= 0) begin
                upd = 1; idx = tgt; act = 1;
                starts++;
                m_stamp[tgt] = starts;
                m_valid[tgt] = 1;
                m_note[tgt]  = note;
            end else drop = 1;
        end else begin
            if (match >= 0) begin
                upd = 1; idx = match; act = 0;
                m_valid[match] = 0;
            end else drop = 1;
        end
    endtask

    task automatic chk_table(input string tag);
        for (int i = 0; i < VC; i++) begin
            chk({tag, "_valid"}, 32'(slot_valid[i]), 32'(m_valid[i]));
            chk({tag, "_note"},  32'(slot_note[i]),  32'(m_note[i]));
        end
    endtask

    // Starts at a negedge; ends at the negedge of cycle t+3.
    task automatic run_event(input bit on, input int note, input bit use_tab, input vec_t v,
                             input string tag);
        bit eu, ea, ed;
        int ei;
        int w = 0;
        bit mu, ma, md;
        int mi;
        model_apply(on, note, mu, mi, ma, md);
        if (use_tab) begin eu = v.upd; ei = v.idx; ea = v.act; ed = v.drop; end
        else begin eu = mu; ei = mi; ea = ma; ed = md; end
        while (!event_ready && w < 10) begin @(negedge clk); w++; end
        chk({tag, "_ready_t"}, 32'(event_ready), 1);
        event_valid = 1'b1; event_on = on; event_note = NW'(note);
        @(negedge clk);
        // Junk offered while busy must be ignored.
        event_valid = 1'($urandom); event_on = 1'($urandom); event_note = NW'($urandom);
        chk({tag, "_ready_t1"}, 32'(event_ready), 0);
        chk({tag, "_upd_t1"}, 32'(update_valid | dropped), 0);
        @(negedge clk);
        event_valid = 1'b0;
        chk({tag, "_ready_t2"}, 32'(event_ready), 0);
        chk({tag, "_upd_t2"}, 32'(update_valid), 32'(eu));
        chk({tag, "_drop_t2"}, 32'(dropped), 32'(ed));
        if (eu) begin
            chk({tag, "_idx"}, 32'(update_index), 32'(ei));
            chk({tag, "_act"}, 32'(update_active), 32'(ea));
            chk({tag, "_unote"}, 32'(update_note), 32'(note));
        end
        @(negedge clk);
        chk({tag, "_ready_t3"}, 32'(event_ready), 1);
        chk({tag, "_pulse_t3"}, 32'(update_valid | dropped), 0);
        if (use_tab) chk({tag, "_mask"}, 32'(slot_valid), 32'(v.valid));
        chk_table(tag);
    endtask

    task automatic do_reset();
        event_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic add(input bit on, input int note, input bit upd, input int idx,
                       input bit act, input bit drop, input bit [7:0] valid);
        vec_t v;
        v.on = on; v.note = note; v.upd = upd; v.idx = idx;
        v.act = act; v.drop = drop; v.valid = valid;
        tab.push_back(v);
    endtask

    initial begin
        vec_t none;
        bit on;
        none = '{on: 0, note: 0, upd: 0, idx: 0, act: 0, drop: 0, valid: 0};

        // Reset state
        do_reset();
        chk("rst_ready", 32'(event_ready), 1);
        chk("rst_slot_valid", 32'(slot_valid), 0);
        chk("rst_update", {update_valid, update_active, dropped, 29'(update_index)}, 0);
        chk("rst_update_note", 32'(update_note), 0);
        chk_table("rst");

        // Allocate, retrigger, release, reuse, unmatched note-off
        add(1, 60, 1, 0, 1, 0, 8'h01);
        add(1, 60, 1, 0, 1, 0, 8'h01);
        add(1, 62, 1, 1, 1, 0, 8'h03);
        add(0, 60, 1, 0, 0, 0, 8'h02);
        add(1, 64, 1, 0, 1, 0, 8'h03);
        add(0, 70, 0, 0, 0, 1, 8'h03);
        for (int k = 0; k < tab.size(); k++)
            run_event(tab[k].on, tab[k].note, 1'b1, tab[k], $sformatf("dirA%0d", k));
        chk("dirA_slot1_note", 32'(slot_note[1]), 62);

        // Fill table with 60..67 then one more note-on
        do_reset();
        tab.delete();
        for (int k = 0; k < VC; k++)
            add(1, 60 + k, 1, k, 1, 0, 8'((16'd1 << (k + 1)) - 1));
        add(1, 70, STEAL, 0, STEAL, !STEAL, 8'hFF);
        for (int k = 0; k < tab.size(); k++)
            run_event(tab[k].on, tab[k].note, 1'b1, tab[k], $sformatf("dirB%0d", k));
        chk("dirB_slot0_note", 32'(slot_note[0]), STEAL ? 70 : 60);

        // Reset during LOOKUP of an in-flight note-on
        event_valid = 1'b1; event_on = 1'b1; event_note = 7'd20;
        @(negedge clk);
        event_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("midrst_pulse", 32'(update_valid | dropped), 0);
        chk("midrst_valid", 32'(slot_valid), 0);
        chk("midrst_ready", 32'(event_ready), 1);
        @(negedge clk);
        chk("midrst_pulse2", 32'(update_valid | dropped), 0);

        // Randomized events against the model
        for (int k = 0; k < 300; k++) begin
            on = ($urandom_range(0, 99) < 60);
            run_event(on, 56 + $urandom_range(0, 15), 1'b0, none, $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
